n2_cpu_core: RTL and testbench
==============================

// Module: n2_cpu_core
// PURPOSE
//  Parametrised multi-cycle successor to the n1 toy CPU: fetch/exec FSM over an internal
//  synchronous-read program/data RAM, NREGS GPRs, NZCV flags, bounded hardware call stack.
//  Adds a program-load port, run/halt control, an out_valid strobe and fault detection
//  (div-by-zero, stack over/underflow, illegal opcode). Sits directly under the TT top wrapper.
// PARAMETERS
//  DATA_W      16  register/RAM word width (>=16; instruction = low 16 bits of a word)
//  ADDR_W      7   RAM address bits (<=8); depth = 2**ADDR_W words
//  NREGS       4   general-purpose registers (power of 2, 2..8)
//  STACK_DEPTH 8   call-stack entries (return PCs, ADDR_W wide)
// PORTS
//  clk        in   1       clock; all state on posedge
//  rst        in   1       synchronous, active-high reset
//  run        in   1       pulse: start execution at pc=0 (accepted in IDLE or HALT only)
//  load_en    in   1       write load_data to RAM[load_addr]; honoured only in IDLE/HALT/FAULT
//  load_addr  in   ADDR_W  program-load address
//  load_data  in   DATA_W  program-load data
//  out_data   out  DATA_W  last OUT value (holds until next OUT)
//  out_valid  out  1       one-cycle strobe when out_data updates
//  busy       out  1       high in FETCH/EXEC/MEM
//  halted     out  1       high in HALT
//  fault      out  1       high in FAULT (sticky until rst)
//  fault_code out  2       0 none,1 div0,2 stack ovf/unf,3 illegal opcode
//  pc_dbg     out  ADDR_W  current pc
// BEHAVIOUR
//  Reset: state=IDLE; pc,sp,regs,NZCV,out_data,fault_code=0; out_valid=0. RAM not reset.
//  States: IDLE -run-> FETCH; FETCH (RAM read at pc issued) -> EXEC; EXEC -> FETCH | MEM | HALT | FAULT;
//   MEM (RAM read data back) -> FETCH; HALT -run-> FETCH; FAULT exits only via rst.
//  run in IDLE/HALT: pc=0, sp=0, NZCV=0, regs kept. run while busy ignored.
//  Latency: ALU/jump/call/ret/MOVI/STORE = 2 cycles; LOAD/OUT = 3 cycles.
//  Decode: op=inst[15:12]; rd=inst[11:9], ra=inst[8:6], rb=inst[5:3] (low log2(NREGS) bits used);
//   a8=inst[7:0] truncated to ADDR_W; imm8 zero-extended to DATA_W.
//  Opcodes: 0 NOP; 1 MOVI rd=imm8; 2 STORE RAM[a8]=rd; 3 ADD rd=ra+rb; 4 SUB rd=ra-rb;
//   5 MUL rd=low DATA_W of ra*rb; 6 DIV rd=ra/rb unsigned; 7 OUT out_data=RAM[a8];
//   8 HALT; 9 CMP Z=(rd==ra),N=(rd<ra) unsigned; A JMP; B JNE if !Z; C JLE if N|Z;
//   D CALL push pc+1, pc=a8; E RET pc=pop; F LOAD rd=RAM[a8].
//  Flags: ADD/SUB set N=msb,Z,C (carry-out / borrow),V (signed ovf); CMP sets Z,N only;
//   all other ops leave flags. Flag writes use the result, not stale register values.
//  pc increments modulo 2**ADDR_W (wraps to 0); jumps/calls load a8 directly.
//  Faults (entered from EXEC, no state update by faulting instruction): DIV with rb==0 -> code1;
//   CALL with sp==STACK_DEPTH or RET with sp==0 -> code2; op unused in future revisions -> code3
//   (none currently; reserved). First fault code latches.
//  STORE to the address currently being fetched: next FETCH sees new data (write-first).
//  load_en concurrent with run: write completes, execution starts from pc=0 same cycle.
//  rst mid-instruction: aborts immediately, no partial register/RAM write beyond that edge.
// STRUCTURE
//  n2_pkg: opcode localparams/enum, state enum (IDLE,FETCH,EXEC,MEM,HALT,FAULT), fault codes.
//  Sub-module n2_call_stack (push/pop/full/empty, STACK_DEPTH x ADDR_W, sync reset of sp only).
//  RAM, regfile, ALU and FSM inline in n2_cpu_core.
// TESTING
//  Load {MOVI r0,5; MOVI r1,7; ADD r2,r0,r1; STORE r2,@20; OUT @20; HALT}, run -> out_valid once,
//   out_data=12, halted after 2+2+2+2+3+2=13 cycles.
//  Countdown loop r0=3, r1=1, SUB/CMP/JNE -> JNE taken twice, falls through; r0=0, Z=1.
//  CALL depth STACK_DEPTH+1 recursion -> fault=1, fault_code=2, pc frozen at faulting CALL.
//  DIV r2,r0,r1 with r1=0 -> fault_code=1, r2 unchanged; later run pulse ignored until rst.
//  ADD 0xFFFF+0x0001 -> r=0, Z=1, C=1, V=0; SUB 0x8000-0x0001 -> 0x7FFF, V=1, C=0.
//  Assert rst during LOAD's MEM cycle -> next cycle IDLE, all outputs at reset values, rd unchanged.

Source files
------------

// File: rtl/n2_pkg.sv
// n2_pkg: shared definitions for the n2 multi-cycle CPU core.
//   opcode_e : 4-bit instruction opcodes (inst[15:12])
//   state_e  : control FSM states
//   fault_e  : fault_code encodings
package n2_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOVI  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_DIV   = 4'h6,
    OP_OUT   = 4'h7,
    OP_HALT  = 4'h8,
    OP_CMP   = 4'h9,
    OP_JMP   = 4'hA,
    OP_JNE   = 4'hB,
    OP_JLE   = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_LOAD  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DIV0    = 2'd1,
    FC_STACK   = 2'd2,
    FC_ILLEGAL = 2'd3
  } fault_e;

endpackage

// File: rtl/n2_call_stack.sv
// n2_call_stack: bounded LIFO of return addresses for CALL/RET.
//   clk, rst   : clock, synchronous active-high reset (clears sp only)
//   clear      : synchronous empty request (new program run)
//   push, pop  : push push_data / pop top; ignored when full / empty
//   push_data  : return address to store
//   top        : entry at the top of the stack (valid when !empty)
//   full/empty : sp == DEPTH / sp == 0
module n2_call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic           unused_sp;

  assign full      = (sp == SPW'(DEPTH));
  assign empty     = (sp == '0);
  assign sp_dec    = sp - 1'b1;
  assign top       = mem[sp_dec[IW-1:0]];
  assign unused_sp = ^sp_dec;

  always_ff @(posedge clk) begin
    if (rst || clear)
      sp <= '0;
    else if (push && !full)
      sp <= sp + 1'b1;
    else if (pop && !empty)
      sp <= sp_dec;
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push && !full)
      mem[sp[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/n2_cpu_core.sv
// n2_cpu_core: multi-cycle fetch/exec CPU with internal sync-read RAM,
// NREGS GPRs, NZCV flags and a bounded hardware call stack.
//   clk, rst              : clock, synchronous active-high reset
//   run                   : start at pc=0 (IDLE/HALT only)
//   load_en/addr/data     : program-load write port (IDLE/HALT/FAULT only)
//   out_data, out_valid   : last OUT value and its one-cycle update strobe
//   busy, halted, fault   : FETCH/EXEC/MEM, HALT, FAULT status
//   fault_code            : 0 none, 1 div0, 2 stack ovf/unf, 3 illegal op
//   pc_dbg                : current pc
//
// state | meaning
// IDLE  | after reset, waiting for run
// FETCH | RAM read at pc issued
// EXEC  | instruction in ram_q; execute, or issue data read for LOAD/OUT
// MEM   | data read returned; write rd or out_data
// HALT  | stopped by HALT, run restarts at pc=0
// FAULT | stopped by a fault, left only through rst
module n2_cpu_core
  import n2_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 7,
  parameter int NREGS       = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] pc_dbg
);
  localparam int RW    = $clog2(NREGS);
  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, pc_inc;
  logic [DATA_W-1:0] regs [NREGS];
  logic [3:0]        flags, flags_nx;   // {N, Z, C, V}
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [1:0]        fault_q, fault_nx;
  logic [RW-1:0]     mem_rd;
  logic              mem_is_out;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;

  logic              reg_we;
  logic [RW-1:0]     reg_wa;
  logic [DATA_W-1:0] reg_wd;
  logic              out_we;

  logic              stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  opcode_e           op;
  logic [RW-1:0]     rd, ra, rb;
  logic [ADDR_W-1:0] a8;
  logic [DATA_W-1:0] imm, va, vb, vd;
  logic [DATA_W:0]   sum_w, diff_w;
  logic [DATA_W-1:0] mul_lo, div_q;
  logic              add_v, sub_v;
  logic              unused_bits;

  // Instruction fields come straight from the RAM output register in EXEC.
  assign op  = opcode_e'(ram_q[15:12]);
  assign rd  = ram_q[9 +: RW];
  assign ra  = ram_q[6 +: RW];
  assign rb  = ram_q[3 +: RW];
  assign a8  = ram_q[ADDR_W-1:0];
  assign imm = {{(DATA_W-8){1'b0}}, ram_q[7:0]};
  assign unused_bits = ^ram_q;

  assign va = regs[ra];
  assign vb = regs[rb];
  assign vd = regs[rd];

  assign sum_w  = {1'b0, va} + {1'b0, vb};
  assign diff_w = {1'b0, va} - {1'b0, vb};   // msb = borrow
  assign mul_lo = va * vb;
  assign div_q  = (vb == '0) ? '0 : va / vb;
  assign add_v  = (va[DATA_W-1] == vb[DATA_W-1]) && (sum_w[DATA_W-1]  != va[DATA_W-1]);
  assign sub_v  = (va[DATA_W-1] != vb[DATA_W-1]) && (diff_w[DATA_W-1] != va[DATA_W-1]);

  assign pc_inc = pc + 1'b1;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  assign busy       = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MEM);
  assign halted     = (state == ST_HALT);
  assign fault      = (state == ST_FAULT);
  assign fault_code = fault_q;
  assign pc_dbg     = pc;

  n2_call_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    flags_nx  = flags;
    fault_nx  = fault_q;
    reg_we    = 1'b0;
    reg_wa    = rd;
    reg_wd    = '0;
    out_we    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = load_addr;
    ram_wdata = load_data;
    ram_raddr = pc;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;

    if (load_en && (state == ST_IDLE || state == ST_HALT || state == ST_FAULT))
      ram_we = 1'b1;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          state_nx  = ST_FETCH;
          pc_nx     = '0;
          flags_nx  = '0;
          stk_clear = 1'b1;
        end
      end
      ST_FETCH: state_nx = ST_EXEC;
      ST_EXEC: begin
        state_nx = ST_FETCH;
        pc_nx    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_MOVI: begin
            reg_we = 1'b1;
            reg_wd = imm;
          end
          OP_STORE: begin
            ram_we    = 1'b1;
            ram_waddr = a8;
            ram_wdata = vd;
          end
          OP_ADD: begin
            reg_we   = 1'b1;
            reg_wd   = sum_w[DATA_W-1:0];
            flags_nx = {sum_w[DATA_W-1], (sum_w[DATA_W-1:0] == '0), sum_w[DATA_W], add_v};
          end
          OP_SUB: begin
            reg_we   = 1'b1;
            reg_wd   = diff_w[DATA_W-1:0];
            flags_nx = {diff_w[DATA_W-1], (diff_w[DATA_W-1:0] == '0), diff_w[DATA_W], sub_v};
          end
          OP_MUL: begin
            reg_we = 1'b1;
            reg_wd = mul_lo;
          end
          OP_DIV: begin
            if (vb == '0) begin
              state_nx = ST_FAULT;
              pc_nx    = pc;
              if (fault_q == FC_NONE) fault_nx = FC_DIV0;
            end else begin
              reg_we = 1'b1;
              reg_wd = div_q;
            end
          end
          OP_OUT, OP_LOAD: begin
            ram_raddr = a8;
            state_nx  = ST_MEM;
          end
          OP_HALT: begin
            state_nx = ST_HALT;
            pc_nx    = pc;
          end
          OP_CMP: begin
            flags_nx[3] = (vd < va);
            flags_nx[2] = (vd == va);
          end
          OP_JMP: pc_nx = a8;
          OP_JNE: if (!flags[2]) pc_nx = a8;
          OP_JLE: if (flags[3] || flags[2]) pc_nx = a8;
          OP_CALL: begin
            if (stk_full) begin
              state_nx = ST_FAULT;
              pc_nx    = pc;
              if (fault_q == FC_NONE) fault_nx = FC_STACK;
            end else begin
              stk_push = 1'b1;
              pc_nx    = a8;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              state_nx = ST_FAULT;
              pc_nx    = pc;
              if (fault_q == FC_NONE) fault_nx = FC_STACK;
            end else begin
              stk_pop = 1'b1;
              pc_nx   = stk_top;
            end
          end
          default: begin
            state_nx = ST_FAULT;
            pc_nx    = pc;
            if (fault_q == FC_NONE) fault_nx = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        state_nx = ST_FETCH;
        if (mem_is_out) begin
          out_we = 1'b1;
        end else begin
          reg_we = 1'b1;
          reg_wa = mem_rd;
          reg_wd = ram_q;
        end
      end
      ST_FAULT: ;
      default: state_nx = ST_IDLE;
    endcase

    // Reset cancels any write the aborted instruction would have made.
    if (rst) ram_we = 1'b0;
  end

  // Write-first: a read of the address being written returns the new word.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_waddr] <= ram_wdata;
    ram_q <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : ram[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      flags      <= '0;
      fault_q    <= FC_NONE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      mem_rd     <= '0;
      mem_is_out <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      pc        <= pc_nx;
      flags     <= flags_nx;
      fault_q   <= fault_nx;
      out_valid <= out_we;
      if (out_we)
        out_data <= ram_q;
      if (reg_we)
        regs[reg_wa] <= reg_wd;
      if (state == ST_EXEC) begin
        mem_rd     <= rd;
        mem_is_out <= (op == OP_OUT);
      end
    end
  end

endmodule

// File: tb/tb_n2_cpu_core.sv
module tb_n2_cpu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        load_en = 1'b0;
  logic [6:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] out_data;
  logic        out_valid, busy, halted, fault;
  logic [1:0]  fault_code;
  logic [6:0]  pc_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // ISA-level reference model state
  logic [15:0] m_mem [128];
  int          m_regs [4];
  bit          m_n, m_z, m_c, m_v;
  int          m_stack [$];
  int          m_outs [$];
  int          m_pc, m_cycles, m_end, m_code;   // m_end: 0 running, 1 halt, 2 fault
  int          d_outs [$];
  int          d_cycles;

  n2_cpu_core dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code),
    .pc_dbg     (pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 128; i++) begin
      load_en   = 1'b1;
      load_addr = 7'(i);
      load_data = m_mem[i];
      @(posedge clk); #1;
    end
    load_en = 1'b0;
  endtask

  function automatic int sgn(input int x);
    return (x >> 15) & 1;
  endfunction

  task automatic model_run(input int max_instr);
    int inst, op, rd, ra, rb, a, va, vb, vd, res, npc;
    m_pc = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    m_stack.delete(); m_outs.delete();
    m_cycles = 0; m_end = 0; m_code = 0;
    for (int k = 0; k < max_instr && m_end == 0; k++) begin
      inst = int'(m_mem[m_pc]);
      op = (inst >> 12) & 15; rd = (inst >> 9) & 3;
      ra = (inst >> 6) & 3;   rb = (inst >> 3) & 3;
      a  = inst & 127;
      va = m_regs[ra]; vb = m_regs[rb]; vd = m_regs[rd];
      npc = (m_pc + 1) % 128;
      m_cycles += 2;
      case (op)
        1: m_regs[rd] = inst & 255;
        2: m_mem[a] = 16'(vd);
        3: begin
          res = (va + vb) & 'hFFFF;
          m_c = (va + vb) > 'hFFFF;
          m_v = (sgn(va) == sgn(vb)) && (sgn(res) != sgn(va));
          m_n = sgn(res) == 1; m_z = (res == 0);
          m_regs[rd] = res;
        end
        4: begin
          res = (va - vb) & 'hFFFF;
          m_c = va < vb;
          m_v = (sgn(va) != sgn(vb)) && (sgn(res) != sgn(va));
          m_n = sgn(res) == 1; m_z = (res == 0);
          m_regs[rd] = res;
        end
        5: m_regs[rd] = int'((longint'(va) * longint'(vb)) & 'hFFFF);
        6: if (vb == 0) begin m_end = 2; m_code = 1; npc = m_pc; end
           else m_regs[rd] = va / vb;
        7: begin m_outs.push_back(int'(m_mem[a])); m_cycles += 1; end
        8: begin m_end = 1; npc = m_pc; end
        9: begin m_z = (vd == va); m_n = (vd < va); end
        10: npc = a;
        11: if (!m_z) npc = a;
        12: if (m_n || m_z) npc = a;
        13: if (m_stack.size() == 8) begin m_end = 2; m_code = 2; npc = m_pc; end
            else begin m_stack.push_back(npc); npc = a; end
        14: if (m_stack.size() == 0) begin m_end = 2; m_code = 2; npc = m_pc; end
            else npc = m_stack.pop_back();
        15: begin m_regs[rd] = int'(m_mem[a]); m_cycles += 1; end
        default: ;
      endcase
      m_pc = npc;
    end
  endtask

  // Loads m_mem, runs model and DUT from pc=0, compares everything visible.
  task automatic run_prog(input string tag, input int max_instr);
    load_all();
    model_run(max_instr);
    d_outs.delete();
    d_cycles = -1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    if (m_end != 0) begin
      for (int c = 1; c <= m_cycles + 10; c++) begin
        @(posedge clk); #1;
        if (out_valid) d_outs.push_back(int'(out_data));
        if (!busy) begin d_cycles = c; break; end
      end
      check($sformatf("%s_cycles", tag), d_cycles, m_cycles);
      check($sformatf("%s_halted", tag), int'(halted), (m_end == 1) ? 1 : 0);
      check($sformatf("%s_fault", tag), int'(fault), (m_end == 2) ? 1 : 0);
      check($sformatf("%s_code", tag), int'(fault_code), m_code);
      if (m_end == 2) check($sformatf("%s_fpc", tag), int'(pc_dbg), m_pc);
    end else begin
      for (int c = 1; c <= m_cycles; c++) begin
        @(posedge clk); #1;
        if (out_valid) d_outs.push_back(int'(out_data));
      end
      check($sformatf("%s_busy", tag), int'(busy), 1);
      check($sformatf("%s_pc", tag), int'(pc_dbg), m_pc);
    end
    check($sformatf("%s_nout", tag), d_outs.size(), m_outs.size());
    for (int i = 0; i < d_outs.size() && i < m_outs.size(); i++)
      check($sformatf("%s_out%0d", tag, i), d_outs[i], m_outs[i]);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_r%0d", tag, i), int'(dut.regs[i]), m_regs[i]);
    check($sformatf("%s_flags", tag),
          int'({dut.flag_n, dut.flag_z, dut.flag_c, dut.flag_v}),
          int'({m_n, m_z, m_c, m_v}));
  endtask

  task automatic clear_mem(input logic [15:0] w);
    for (int i = 0; i < 128; i++) m_mem[i] = w;
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    logic [3:0] op;
    r  = $urandom_range(0, 19);
    op = (r > 15) ? 4'h1 : r[3:0];
    return {op, 12'($urandom)};
  endfunction

  initial begin
    do_reset();
    check("rst_busy",   int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_fault",  int'(fault), 0);
    check("rst_code",   int'(fault_code), 0);
    check("rst_ovalid", int'(out_valid), 0);
    check("rst_odata",  int'(out_data), 0);
    check("rst_pc",     int'(pc_dbg), 0);

    // Reference program from the block description.
    clear_mem(16'h0000);
    m_mem[0] = 16'h1005; m_mem[1] = 16'h1207; m_mem[2] = 16'h3408;
    m_mem[3] = 16'h2414; m_mem[4] = 16'h7014; m_mem[5] = 16'h8000;
    run_prog("basic", 50);
    check("basic_cyc13", d_cycles, 13);
    check("basic_nout1", d_outs.size(), 1);
    if (d_outs.size() > 0) check("basic_out12", d_outs[0], 12);

    // Countdown loop: JNE taken twice then falls through.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'h1003; m_mem[1] = 16'h1201; m_mem[2] = 16'h1600;
    m_mem[3] = 16'h4008; m_mem[4] = 16'h90C0; m_mem[5] = 16'hB003;
    m_mem[6] = 16'h2028; m_mem[7] = 16'h7028; m_mem[8] = 16'h8000;
    run_prog("loop", 60);
    check("loop_cyc31", d_cycles, 31);
    check("loop_r0", int'(dut.regs[0]), 0);
    check("loop_z",  int'(dut.flag_z), 1);

    // ADD 0xFFFF + 1.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'h1000; m_mem[1] = 16'h1201; m_mem[2] = 16'h4008;
    m_mem[3] = 16'h3408; m_mem[4] = 16'h8000;
    run_prog("addc", 20);
    check("addc_r2", int'(dut.regs[2]), 0);
    check("addc_zcv", int'({dut.flag_z, dut.flag_c, dut.flag_v}), 3'b110);

    // SUB 0x8000 - 1.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'h1080; m_mem[1] = 16'h1201; m_mem[2] = 16'h5000;
    m_mem[3] = 16'h3000; m_mem[4] = 16'h4408; m_mem[5] = 16'h8000;
    run_prog("subv", 20);
    check("subv_r2", int'(dut.regs[2]), 'h7FFF);
    check("subv_cv", int'({dut.flag_c, dut.flag_v}), 2'b01);

    // Unbounded recursion overflows the call stack.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'hD000;
    run_prog("ovf", 40);
    check("ovf_code2", int'(fault_code), 2);
    check("ovf_pc0",   int'(pc_dbg), 0);
    check("ovf_cyc18", d_cycles, 18);

    // Divide by zero, then run must be ignored until rst.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'h1409; m_mem[1] = 16'h1006; m_mem[2] = 16'h6408; m_mem[3] = 16'h8000;
    run_prog("div0", 20);
    check("div0_code1", int'(fault_code), 1);
    check("div0_r2",    int'(dut.regs[2]), 9);
    run = 1'b1; @(posedge clk); #1; run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("div0_run_fault", int'(fault), 1);
    check("div0_run_busy",  int'(busy), 0);
    check("div0_run_pc",    int'(pc_dbg), 2);
    do_reset();
    check("div0_rst_fault", int'(fault), 0);
    check("div0_rst_code",  int'(fault_code), 0);

    // Reset during LOAD's MEM cycle.
    do_reset();
    clear_mem(16'h0000);
    m_mem[0] = 16'hF232; m_mem[50] = 16'h1234;
    load_all();
    run = 1'b1; @(posedge clk); #1; run = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mrst_in_mem", int'(busy), 1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("mrst_busy", int'(busy), 0);
    check("mrst_halt", int'(halted), 0);
    check("mrst_ov",   int'(out_valid), 0);
    check("mrst_pc",   int'(pc_dbg), 0);
    check("mrst_r1",   int'(dut.regs[1]), 0);
    @(posedge clk); #1;
    check("mrst_r1b",  int'(dut.regs[1]), 0);

    // load_en in the same cycle as run: the new word is fetched.
    do_reset();
    clear_mem(16'h8000);
    m_mem[60] = 16'h0ABC;
    load_all();
    load_en = 1'b1; load_addr = 7'd0; load_data = 16'h703C; run = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; run = 1'b0;
    d_outs.delete();
    d_cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) d_outs.push_back(int'(out_data));
      if (!busy) begin d_cycles = c; break; end
    end
    check("ldrun_cyc", d_cycles, 5);
    check("ldrun_nout", d_outs.size(), 1);
    check("ldrun_data", int'(out_data), 'hABC);
    check("ldrun_halt", int'(halted), 1);

    // Random programs against the reference model.
    for (int t = 0; t < 25; t++) begin
      do_reset();
      for (int i = 0; i < 128; i++) m_mem[i] = rand_word();
      run_prog($sformatf("rnd%0d", t), 40);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
